// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - iterative RV M-extension multiply/divide engine
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module rv_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          fn_q, fn_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic                sa_q, sa_d;
   logic                sb_q, sb_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                is_div, a_signed, b_signed, a_sgn, b_sgn;
   logic                div_zero, div_ovf;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       mul_sum, div_diff;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quot, rem;

   // Operand signedness decoded from funct3 at launch; unsigned ops keep sign=0.
   assign is_div   = funct3[2];
   assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
   assign a_sgn    = a_signed & op_a[XLEN-1];
   assign b_sgn    = b_signed & op_b[XLEN-1];
   assign a_mag    = a_sgn ? -op_a : op_a;
   assign b_mag    = b_sgn ? -op_b : op_b;
   assign div_zero = (op_b == '0);
   assign div_ovf  = ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
   assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
   assign prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quot     = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem      = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      state_d  = state_q;
      fn_d     = fn_q;
      a_d      = a_q;
      b_d      = b_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               fn_d  = funct3;
               a_d   = a_mag;
               b_d   = b_mag;
               sa_d  = a_sgn;
               sb_d  = b_sgn;
               acc_d = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
               cnt_d = CNT_W'(XLEN - 1);
               if (is_div && div_zero) begin
                  result_d = funct3[1] ? op_a : '1;
                  state_d  = S_DONE;
               end else if (is_div && div_ovf) begin
                  result_d = funct3[1] ? '0 : op_a;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               if (fn_q[2]) begin
                  // Restoring step: the shifted remainder can need XLEN+1 bits.
                  if (!div_diff[XLEN])
                     acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                  else
                     acc_d = {acc_q[2*XLEN-2:0], 1'b0};
               end else if (acc_q[0]) begin
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
               end else begin
                  acc_d = {1'b0, acc_q[2*XLEN-1:1]};
               end
               if (cnt_q == '0)
                  state_d = S_FIX;
               else
                  cnt_d = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               if (fn_q[2])
                  result_d = fn_q[1] ? rem : quot;
               else
                  result_d = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= S_IDLE;
         fn_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         fn_q     <= fn_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule
